// File: rtl/reg_file_32x64.sv
// 32 x WIDTH register file: X0..X30 in flops, X31 (XZR) hardwired to zero; two read ports, one write port.
// Reads are combinational with same-cycle write bypass; writes commit on the rising clk edge, never stall.
module reg_file_32x64 #(
  parameter int WIDTH = 64,
  parameter int NREGS = 32,
  parameter int ZREG  = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  logic [NREGS-1:0] wr_en;
  logic [WIDTH-1:0] reg_out [NREGS];

  // One-hot write decode; the XZR slot is never enabled, which also keeps it out of the bypass.
  always_comb begin
    wr_en = '0;
    if (RegWrite && !reset) begin
      wr_en[WriteRegister] = 1'b1;
    end
    wr_en[ZREG] = 1'b0;
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (i == ZREG) begin : g_zero
      assign reg_out[i] = '0;
    end else begin : g_ff
      logic [WIDTH-1:0] x_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          x_q <= '0;
        end else if (wr_en[i]) begin
          x_q <= WriteData;
        end
      end
      assign reg_out[i] = x_q;
    end
  end

  always_comb begin
    ReadData1 = reg_out[ReadRegister1];
    if (wr_en[ReadRegister1]) begin
      ReadData1 = WriteData;
    end
    if (reset) begin
      ReadData1 = '0;
    end
  end

  always_comb begin
    ReadData2 = reg_out[ReadRegister2];
    if (wr_en[ReadRegister2]) begin
      ReadData2 = WriteData;
    end
    if (reset) begin
      ReadData2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_32x64.sv
// Randomised + directed bench for reg_file_32x64 against an array-based architectural model.
module tb_reg_file_32x64;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         RegWrite;
  logic [4:0]   WriteRegister;
  logic [W-1:0] WriteData;
  logic [4:0]   ReadRegister1;
  logic [4:0]   ReadRegister2;
  logic [W-1:0] ReadData1;
  logic [W-1:0] ReadData2;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] mdl [32];

  always #5 clk = ~clk;

  reg_file_32x64 #(.WIDTH(W), .NREGS(32), .ZREG(31)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Architectural read: zero in reset or for XZR, pending write wins, else stored value.
  function automatic logic [W-1:0] ref_rd(input logic [4:0] a);
    if (reset || a == 5'd31) return '0;
    if (RegWrite && WriteRegister == a) return WriteData;
    return mdl[a];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 32; k++) mdl[k] = '0;
  endtask

  task automatic check_reads(input string tag);
    #1;
    chk({tag, "_rd1"}, ReadData1, ref_rd(ReadRegister1));
    chk({tag, "_rd2"}, ReadData2, ref_rd(ReadRegister2));
  endtask

  task automatic commit();
    @(posedge clk);
    if (!reset && RegWrite && WriteRegister != 5'd31) mdl[WriteRegister] = WriteData;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [4:0] r, input logic [W-1:0] d);
    RegWrite = 1'b1; WriteRegister = r; WriteData = d;
    commit();
    RegWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    clear_model();
    @(negedge clk);

    // Reset value on every index of both ports
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
      #1;
      chk("rst_rd1", ReadData1, 64'h0);
      chk("rst_rd2", ReadData2, 64'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Write then read
    do_write(5'd5, 64'hDEAD_BEEF_0123_4567);
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd4;
    #1;
    chk("wr_x5", ReadData1, 64'hDEAD_BEEF_0123_4567);
    chk("rd_x4", ReadData2, 64'h0);

    // Sweep
    for (int i = 0; i < 31; i++) do_write(5'(i), 64'(i) * 64'h0101_0101_0101_0101);
    for (int i = 0; i < 31; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(i);
      #1;
      chk("sweep_rd1", ReadData1, 64'(i) * 64'h0101_0101_0101_0101);
      chk("sweep_rd2", ReadData2, 64'(i) * 64'h0101_0101_0101_0101);
    end
    @(negedge clk);

    // XZR
    RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = '1;
    ReadRegister1 = 5'd31; ReadRegister2 = 5'd0;
    #1;
    chk("xzr_same", ReadData1, 64'h0);
    commit();
    RegWrite = 1'b0;
    #1;
    chk("xzr_next", ReadData1, 64'h0);
    for (int i = 0; i < 31; i++) begin
      ReadRegister2 = 5'(i);
      #1;
      chk("xzr_keep", ReadData2, 64'(i) * 64'h0101_0101_0101_0101);
    end
    @(negedge clk);

    // Bypass
    do_write(5'd7, 64'h1);
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h2A;
    ReadRegister1 = 5'd7; ReadRegister2 = 5'd7;
    #1;
    chk("byp_rd1", ReadData1, 64'h2A);
    chk("byp_rd2", ReadData2, 64'h2A);
    commit();
    RegWrite = 1'b0;
    #1;
    chk("byp_post1", ReadData1, 64'h2A);
    chk("byp_post2", ReadData2, 64'h2A);
    WriteData = 64'h99;
    #1;
    chk("nowr_rd1", ReadData1, 64'h2A);
    commit();
    #1;
    chk("nowr_post1", ReadData1, 64'h2A);
    chk("nowr_post2", ReadData2, 64'h2A);
    @(negedge clk);

    // Reset mid-operation with a pending write
    do_write(5'd3, 64'h55);
    RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'hAA;
    ReadRegister1 = 5'd3; ReadRegister2 = 5'd5;
    #1;
    chk("pre_rst_byp", ReadData1, 64'hAA);
    reset = 1'b1;
    clear_model();
    #1;
    chk("mid_rst_x3", ReadData1, 64'h0);
    chk("mid_rst_x5", ReadData2, 64'h0);
    commit();
    RegWrite = 1'b0;
    reset = 1'b0;
    #1;
    chk("post_rst_x3", ReadData1, 64'h0);
    chk("post_rst_x5", ReadData2, 64'h0);
    commit();
    #1;
    chk("post_rst2_x3", ReadData1, 64'h0);
    @(negedge clk);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      if (reset) clear_model();
      RegWrite = $urandom_range(0, 1);
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData = {$urandom, $urandom};
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister2 = ($urandom_range(0, 3) == 0) ? ReadRegister1 : 5'($urandom_range(0, 31));
      check_reads("rand");
      commit();
    end
    reset = 1'b0; RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
      check_reads("final");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
